mario_input_ctrl: RTL and testbench



---
 rtl/mario_input_ctrl_if.sv | 23 ++
 rtl/mario_input_ctrl.sv | 119 +++++++++++
 tb/tb_mario_input_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mario_input_ctrl_if.sv
// Keyboard-report-in / movement-command-out bundle between the HID front end and the input controller.
interface mario_input_ctrl_if;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [7:0] keycode2;
    logic [7:0] keycode3;
    logic [7:0] keycode_out;
    logic       move_left;
    logic       move_right;
    logic       crouch;
    logic       jump_pulse;
    logic [2:0] run_speed;

    modport master (
        output keycode0, keycode1, keycode2, keycode3,
        input  keycode_out, move_left, move_right, crouch, jump_pulse, run_speed
    );

    modport slave (
        input  keycode0, keycode1, keycode2, keycode3,
        output keycode_out, move_left, move_right, crouch, jump_pulse, run_speed
    );
endinterface

// File: rtl/mario_input_ctrl.sv
// Per-frame keyboard conditioning: last-pressed-wins direction, run-speed ramp,
// edge-triggered jump with cooldown lockout, and a single resolved keycode.
module mario_input_ctrl #(
    parameter logic [7:0] KEY_LEFT      = 8'h04,
    parameter logic [7:0] KEY_RIGHT     = 8'h07,
    parameter logic [7:0] KEY_DOWN      = 8'h16,
    parameter logic [7:0] KEY_JUMP      = 8'h1A,
    parameter int         ACCEL_FRAMES  = 8,
    parameter int         MAX_SPEED     = 4,
    parameter int         JUMP_COOLDOWN = 20
) (
    input  logic               frame_clk,
    input  logic               Reset,
    mario_input_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {NEUTRAL, LEFT, RIGHT} dir_e;

    dir_e       dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cd_q, cd_d;
    logic [2:0] spd_q, spd_d;
    logic       jump_prev_q, left_prev_q, right_prev_q;
    logic       jump_q, jump_d;
    logic       crouch_q, crouch_d;
    logic [7:0] kc_q, kc_d;

    logic left_held, right_held, down_held, jump_held;
    logic left_new, right_new;

    // Slot order and duplicates are irrelevant: a key is held if any slot carries it.
    assign left_held  = (bus.keycode0 == KEY_LEFT)  | (bus.keycode1 == KEY_LEFT)
                      | (bus.keycode2 == KEY_LEFT)  | (bus.keycode3 == KEY_LEFT);
    assign right_held = (bus.keycode0 == KEY_RIGHT) | (bus.keycode1 == KEY_RIGHT)
                      | (bus.keycode2 == KEY_RIGHT) | (bus.keycode3 == KEY_RIGHT);
    assign down_held  = (bus.keycode0 == KEY_DOWN)  | (bus.keycode1 == KEY_DOWN)
                      | (bus.keycode2 == KEY_DOWN)  | (bus.keycode3 == KEY_DOWN);
    assign jump_held  = (bus.keycode0 == KEY_JUMP)  | (bus.keycode1 == KEY_JUMP)
                      | (bus.keycode2 == KEY_JUMP)  | (bus.keycode3 == KEY_JUMP);

    assign left_new  = left_held  & ~left_prev_q;
    assign right_new = right_held & ~right_prev_q;

    always_comb begin
        dir_d = dir_q;
        if (left_held && right_held) begin
            if (left_new && !right_new)      dir_d = LEFT;
            else if (right_new && !left_new) dir_d = RIGHT;
            else if (dir_q == NEUTRAL)       dir_d = LEFT;
        end else if (left_held) begin
            dir_d = LEFT;
        end else if (right_held) begin
            dir_d = RIGHT;
        end else begin
            dir_d = NEUTRAL;
        end

        // A reversal counts as a fresh entry, so speed restarts at 1.
        cnt_d = cnt_q;
        spd_d = spd_q;
        if (dir_d == NEUTRAL) begin
            cnt_d = 8'd0;
            spd_d = 3'd0;
        end else if (dir_d != dir_q) begin
            cnt_d = 8'd0;
            spd_d = 3'd1;
        end else if (cnt_q == 8'(ACCEL_FRAMES - 1)) begin
            cnt_d = 8'd0;
            spd_d = (spd_q >= 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : spd_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        jump_d = jump_held & ~jump_prev_q & (cd_q == 8'd0);
        if (jump_d)              cd_d = 8'(JUMP_COOLDOWN);
        else if (cd_q != 8'd0)   cd_d = cd_q - 8'd1;
        else                     cd_d = 8'd0;

        crouch_d = down_held & (dir_d == NEUTRAL);

        if (jump_d)                kc_d = KEY_JUMP;
        else if (dir_d == LEFT)    kc_d = KEY_LEFT;
        else if (dir_d == RIGHT)   kc_d = KEY_RIGHT;
        else if (crouch_d)         kc_d = KEY_DOWN;
        else                       kc_d = 8'h00;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dir_q        <= NEUTRAL;
            cnt_q        <= 8'd0;
            cd_q         <= 8'd0;
            spd_q        <= 3'd0;
            jump_prev_q  <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            jump_q       <= 1'b0;
            crouch_q     <= 1'b0;
            kc_q         <= 8'h00;
        end else begin
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            cd_q         <= cd_d;
            spd_q        <= spd_d;
            jump_prev_q  <= jump_held;
            left_prev_q  <= left_held;
            right_prev_q <= right_held;
            jump_q       <= jump_d;
            crouch_q     <= crouch_d;
            kc_q         <= kc_d;
        end
    end

    assign bus.keycode_out = kc_q;
    assign bus.move_left   = (dir_q == LEFT);
    assign bus.move_right  = (dir_q == RIGHT);
    assign bus.crouch      = crouch_q;
    assign bus.jump_pulse  = jump_q;
    assign bus.run_speed   = spd_q;
endmodule

// File: tb/tb_mario_input_ctrl.sv
// Scoreboard bench: each frame's stimulus pushes its expected outputs; a monitor pops and compares.
module tb_mario_input_ctrl;
    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    mario_input_ctrl_if bus();

    mario_input_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [7:0] kc;
        logic       l;
        logic       r;
        logic       c;
        logic       j;
        logic [2:0] spd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id   = 0;

    function automatic exp_t actual();
        exp_t a;
        a.kc  = bus.keycode_out;
        a.l   = bus.move_left;
        a.r   = bus.move_right;
        a.c   = bus.crouch;
        a.j   = bus.jump_pulse;
        a.spd = bus.run_speed;
        return a;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got kc=%h l=%b r=%b c=%b j=%b spd=%0d, expected kc=%h l=%b r=%b c=%b j=%b spd=%0d",
                     name, got.kc, got.l, got.r, got.c, got.j, got.spd,
                     exp.kc, exp.l, exp.r, exp.c, exp.j, exp.spd);
        end
    endtask

    // Drive one frame of slots and queue what the outputs must be after the next edge.
    task automatic step(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3,
                        input logic [7:0] kc, input logic l, input logic r, input logic c, input logic j,
                        input logic [2:0] spd);
        exp_t e;
        @(negedge frame_clk);
        bus.keycode0 = k0;
        bus.keycode1 = k1;
        bus.keycode2 = k2;
        bus.keycode3 = k3;
        e.kc = kc; e.l = l; e.r = r; e.c = c; e.j = j; e.spd = spd;
        q.push_back(e);
    endtask

    task automatic idle();
        step(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vec_id++;
                check($sformatf("vec%0d", vec_id), actual(), e);
            end
        end
    end

    initial begin : stim
        exp_t zero;
        logic [2:0] s;
        zero = '0;
        bus.keycode0 = 8'h00;
        bus.keycode1 = 8'h00;
        bus.keycode2 = 8'h00;
        bus.keycode3 = 8'h00;

        #1;
        check("reset_state", actual(), zero);
        @(negedge frame_clk);
        Reset = 1'b0;

        idle();
        idle();

        // Hold left 17 frames: speed 1 at frame 1, 2 at frame 9, 3 at frame 17.
        for (int k = 1; k <= 17; k++) begin
            s = 3'(1 + (k - 1) / 8);
            step(8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, s);
        end
        idle();

        // Left held, right added later wins; releasing right falls back to left.
        for (int k = 1; k <= 4; k++)
            step(8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        step(8'h04, 8'h00, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        step(8'h04, 8'h00, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        step(8'h04, 8'h00, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        step(8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        idle();
        // Both pressed on the same edge from neutral resolves to left.
        step(8'h07, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        idle();

        // Jump: one pulse per press, none while held, dropped during cooldown.
        step(8'h1A, 8'h00, 8'h00, 8'h00, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        for (int k = 2; k <= 30; k++)
            step(8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle();
        step(8'h00, 8'h00, 8'h1A, 8'h00, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        for (int k = 1; k <= 4; k++) idle();
        step(8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 6; k <= 24; k++) idle();
        step(8'h1A, 8'h00, 8'h00, 8'h04, 8'h1A, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        idle();

        // Crouch only while neutral; adding left cancels it.
        step(8'h16, 8'h00, 8'h00, 8'h00, 8'h16, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        step(8'h16, 8'h00, 8'h00, 8'h00, 8'h16, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        step(8'h16, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        idle();

        // Saturation at 4 (reached on frame 25), unknown code 0x55 ignored, duplicate right.
        for (int k = 1; k <= 65; k++) begin
            s = (k >= 25) ? 3'd4 : 3'(1 + (k - 1) / 8);
            step(8'h55, 8'h07, 8'h00, 8'h07, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, s);
        end
        idle();

        // Build up RIGHT at speed 3 with cooldown running, then reset asynchronously.
        step(8'h07, 8'h1A, 8'h00, 8'h00, 8'h1A, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        for (int k = 2; k <= 17; k++) begin
            s = 3'(1 + (k - 1) / 8);
            step(8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, s);
        end
        @(negedge frame_clk);
        bus.keycode0 = 8'h00;
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset", actual(), zero);
        @(negedge frame_clk);
        check("reset_held_edge", actual(), zero);
        Reset = 1'b0;
        idle();
        // Cooldown was cleared by reset, so a jump fires immediately.
        step(8'h1A, 8'h00, 8'h00, 8'h00, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        step(8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        idle();

        repeat (3) @(negedge frame_clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
